// File: rtl/data_sram_like_responder_pkg.sv
// Shared definitions for the data-sram-like responder.
//   SRAM_LIKE_DATA_W  : data word width of the interface
//   SRAM_LIKE_WSTRB_W : number of byte enables on a store
//   RESP_TIMER_W      : width of the per-entry latency countdown
//   resp_entry_t      : one outstanding response {wr, data, timer}
package data_sram_like_responder_pkg;

    localparam int unsigned SRAM_LIKE_DATA_W  = 32;
    localparam int unsigned SRAM_LIKE_WSTRB_W = 4;
    localparam int unsigned RESP_TIMER_W      = 4;

    typedef struct packed {
        logic                        wr;
        logic [SRAM_LIKE_DATA_W-1:0] data;
        logic [RESP_TIMER_W-1:0]     timer;
    } resp_entry_t;

    // Countdown value loaded at enqueue so that data_ok fires LATENCY
    // cycles after the accept cycle.
    function automatic logic [RESP_TIMER_W-1:0] initial_timer(input int unsigned latency);
        return RESP_TIMER_W'(latency - 1);
    endfunction

endpackage

// File: rtl/data_sram_like_responder_resp_queue.sv
// In-order response queue: circular FIFO of MAX_OUT entries, each carrying
// its own countdown to the cycle in which it may be returned.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (flushes all entries)
//   push        : enqueue {push_wr, push_data} with timer = LATENCY-1
//   push_wr     : entry is a store response (returns zero data)
//   push_data   : snapshotted load data
//   pop         : remove the head entry (only when head_ready)
//   head_ready  : head entry valid and its countdown expired
//   head_data   : head data (zero for store entries)
//   count       : number of occupied entries
module data_sram_like_responder_resp_queue
    import data_sram_like_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned MAX_OUT = 2,
    localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1),
    localparam int unsigned PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        push_wr,
    input  logic [SRAM_LIKE_DATA_W-1:0] push_data,
    input  logic                        pop,
    output logic                        head_ready,
    output logic [SRAM_LIKE_DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]            count
);

    resp_entry_t        entries [MAX_OUT];
    logic [MAX_OUT-1:0] valid;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    resp_entry_t        head_entry;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_entry = entries[head];
    assign head_ready = valid[head] && (head_entry.timer == '0);
    assign head_data  = head_entry.wr ? '0 : head_entry.data;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Countdown runs on every occupied slot, not just the head, so
            // that a fixed LATENCY holds regardless of queue position.
            for (int unsigned i = 0; i < MAX_OUT; i++) begin
                if (valid[PTR_W'(i)] && entries[PTR_W'(i)].timer != '0) begin
                    entries[PTR_W'(i)].timer <= entries[PTR_W'(i)].timer - 1'b1;
                end
            end

            if (pop) begin
                valid[head] <= 1'b0;
                head        <= ptr_next(head);
            end

            // The tail slot is always free when push is allowed, so this
            // write never collides with the countdown above.
            if (push) begin
                valid[tail]         <= 1'b1;
                entries[tail].wr    <= push_wr;
                entries[tail].data  <= push_data;
                entries[tail].timer <= initial_timer(LATENCY);
                tail                <= ptr_next(tail);
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_like_responder.sv
// Memory-side responder for the data-sram-like request/response interface.
// Accepts loads/stores into a word-addressed on-chip memory and returns
// in-order responses LATENCY cycles after acceptance.
// Ports:
//   clk, reset : clock, synchronous active-high reset (queue only; memory keeps contents)
//   req        : request valid
//   wr         : 1 = store, 0 = load
//   addr       : byte address, bits [ADDR_W+1:2] select the word
//   wstrb      : store byte enables
//   wdata      : store data
//   addr_ok    : request accepted this cycle when req && addr_ok
//   data_ok    : one-cycle response pulse for the oldest outstanding request
//   rdata      : load data, zero unless data_ok
module data_sram_like_responder
    import data_sram_like_responder_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req,
    input  logic                         wr,
    input  logic [31:0]                  addr,
    input  logic [SRAM_LIKE_WSTRB_W-1:0] wstrb,
    input  logic [31:0]                  wdata,
    output logic                         addr_ok,
    output logic                         data_ok,
    output logic [31:0]                  rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       cur_word;
    logic [31:0]       merged_word;
    logic [31:0]       push_data;
    logic              accept;
    logic              head_ready;
    logic [31:0]       head_data;
    logic [CNT_W-1:0]  count;
    logic              unused_addr_bits;

    // Low byte-offset bits and bits above the word index alias.
    assign word_idx         = addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    // Registered-state-only ready; no path from req.
    assign addr_ok = !reset && (count < CNT_W'(MAX_OUT));
    assign accept  = req && addr_ok;

    assign cur_word = mem[word_idx];

    for (genvar b = 0; b < SRAM_LIKE_WSTRB_W; b++) begin : g_byte
        assign merged_word[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : cur_word[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem[word_idx] <= merged_word;
        end
    end

    // Load data is captured into the queue at the accept edge, so later
    // stores cannot change an already-accepted load's response.
    assign push_data = wr ? '0 : cur_word;

    data_sram_like_responder_resp_queue #(
        .LATENCY (LATENCY),
        .MAX_OUT (MAX_OUT)
    ) u_resp_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_wr    (wr),
        .push_data  (push_data),
        .pop        (data_ok),
        .head_ready (head_ready),
        .head_data  (head_data),
        .count      (count)
    );

    // Gating with reset keeps a response that matures in the reset cycle
    // from pulsing; the flush then discards it.
    assign data_ok = head_ready && !reset;
    assign rdata   = data_ok ? head_data : '0;

endmodule
